randomizer_ctrl: RTL and testbench

//  Per-burst sequencer for the randomizer. Latches a burst request, builds the 15-bit IV

---
 rtl/randomizer_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_randomizer_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/randomizer_ctrl.sv
// ---------------------------------------------------------------------------
// randomizer_ctrl
//
// Per-burst sequencer placed between the MAC-side bit source and the
// randomizer (which itself feeds FEC). One burst runs like this:
//   1. A start request is accepted in IDLE when the lengths are consistent.
//      BSID/UIUC/frame and both lengths are latched at that point.
//   2. LOAD (one cycle) builds the 15-bit IV and pulses rnd_reload_o.
//   3. DATA streams data_len source bits into the randomizer. Each bit
//      arrives one cycle after its src transfer.
//   4. PAD sends 1s, one per cycle, until slot_len bits have been sent.
//   5. DRAIN waits until slot_len randomizer output strobes have been
//      counted, then pulses done_o. If the randomizer stalls for DRAIN_MAX
//      cycles the burst is abandoned with err_timeout_o instead.
//
// Parameters
//   LEN_W      width of the data/slot length counters
//   DRAIN_MAX  stall limit (cycles without rnd_out_valid_i) while in DRAIN
//
// Ports
//   clk_i            system clock
//   reset_i          asynchronous, active-high reset
//   start_i          burst request, accepted only while start_ready_o=1
//   start_ready_o    1 in IDLE
//   cfg_bsid_i       BSID 4 LSBs          (sampled on accepted start)
//   cfg_uiuc_i       UIUC/DIUC            (sampled on accepted start)
//   cfg_frame_i      frame number 4 LSBs  (sampled on accepted start)
//   cfg_data_len_i   payload bits taken from the source
//   cfg_slot_len_i   total bits sent to the randomizer (payload + pad)
//   src_bit_i        source data bit
//   src_valid_i      source bit valid
//   src_ready_o      1 only in DATA; transfer = src_valid_i & src_ready_o
//   rnd_in_bits_o    randomizer input bit            (registered)
//   rnd_in_valid_o   randomizer input valid          (registered)
//   rnd_iv_o         randomizer initial vector       (registered)
//   rnd_reload_o     randomizer reload, 1-cycle pulse (registered)
//   rnd_out_valid_i  randomizer output strobe, counted only
//   busy_o           1 in every state except IDLE
//   done_o           1-cycle pulse, slot_len output bits seen
//   err_cfg_o        1-cycle pulse, start rejected for bad lengths
//   err_timeout_o    1-cycle pulse, DRAIN stalled DRAIN_MAX cycles
// ---------------------------------------------------------------------------
module randomizer_ctrl #(
  parameter int LEN_W     = 16,
  parameter int DRAIN_MAX = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic             start_ready_o,
  input  logic [3:0]       cfg_bsid_i,
  input  logic [3:0]       cfg_uiuc_i,
  input  logic [3:0]       cfg_frame_i,
  input  logic [LEN_W-1:0] cfg_data_len_i,
  input  logic [LEN_W-1:0] cfg_slot_len_i,
  input  logic             src_bit_i,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  output logic             rnd_in_bits_o,
  output logic             rnd_in_valid_o,
  output logic [14:0]      rnd_iv_o,
  output logic             rnd_reload_o,
  input  logic             rnd_out_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_cfg_o,
  output logic             err_timeout_o
);

  // One extra bit of headroom so DRAIN_MAX-1 always fits, even for DRAIN_MAX=1.
  localparam int STALL_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DATA  = 3'd2,
    S_PAD   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Latched burst configuration
  logic [3:0]       bsid_q, bsid_d;
  logic [3:0]       uiuc_q, uiuc_d;
  logic [3:0]       frame_q, frame_d;
  logic [LEN_W-1:0] data_len_q, data_len_d;
  logic [LEN_W-1:0] slot_len_q, slot_len_d;

  // Progress counters
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  // Registered outputs
  logic        in_bits_q, in_bits_d;
  logic        in_valid_q, in_valid_d;
  logic [14:0] iv_q, iv_d;
  logic        reload_q, reload_d;
  logic        done_q, done_d;
  logic        err_cfg_q, err_cfg_d;
  logic        err_timeout_q, err_timeout_d;

  // Decoded conditions
  logic             cfg_ok;
  logic             start_acc;
  logic             start_rej;
  logic             xfer;
  logic [LEN_W-1:0] in_cnt_inc;
  logic             data_last;
  logic             pad_last;
  logic             out_full;
  logic             stall_exp;

  // -------------------------------------------------------------------------
  // Condition decode
  // -------------------------------------------------------------------------
  always_comb begin
    cfg_ok     = (cfg_slot_len_i != '0) && (cfg_slot_len_i >= cfg_data_len_i);
    start_acc  = (state_q == S_IDLE) && start_i && cfg_ok;
    start_rej  = (state_q == S_IDLE) && start_i && !cfg_ok;
    xfer       = (state_q == S_DATA) && src_valid_i;
    in_cnt_inc = in_cnt_q + LEN_W'(1);
    // Equality-only compares: slot_len is bounded below 2^LEN_W, so the
    // counters never wrap before they hit their targets.
    data_last  = xfer && (in_cnt_inc == data_len_q);
    pad_last   = (state_q == S_PAD) && (in_cnt_inc == slot_len_q);
    out_full   = (out_cnt_q == slot_len_q);
    // A strobe arriving in the last allowed cycle still rescues the burst.
    stall_exp  = (state_q == S_DRAIN) && !out_full && !rnd_out_valid_i &&
                 (stall_q == STALL_W'(DRAIN_MAX - 1));
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // An empty payload goes straight to padding.
        state_d = (data_len_q != '0) ? S_DATA : S_PAD;
      end
      S_DATA: begin
        if (data_last) begin
          state_d = (data_len_q == slot_len_q) ? S_DRAIN : S_PAD;
        end
      end
      S_PAD: begin
        if (pad_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_full || stall_exp) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    start_ready_o = (state_q == S_IDLE);
    busy_o        = (state_q != S_IDLE);
    src_ready_o   = (state_q == S_DATA);
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    bsid_d        = bsid_q;
    uiuc_d        = uiuc_q;
    frame_d       = frame_q;
    data_len_d    = data_len_q;
    slot_len_d    = slot_len_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    iv_d          = iv_q;
    in_bits_d     = 1'b0;
    in_valid_d    = 1'b0;
    reload_d      = 1'b0;
    done_d        = 1'b0;
    err_cfg_d     = start_rej;
    err_timeout_d = 1'b0;

    // Output strobes are counted from LOAD onwards regardless of state so
    // any randomizer latency works, including outputs that overlap input.
    // Strobes past slot_len are ignored.
    if ((state_q != S_IDLE) && rnd_out_valid_i && !out_full) begin
      out_cnt_d = out_cnt_q + LEN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          bsid_d     = cfg_bsid_i;
          uiuc_d     = cfg_uiuc_i;
          frame_d    = cfg_frame_i;
          data_len_d = cfg_data_len_i;
          slot_len_d = cfg_slot_len_i;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
        end
      end
      S_LOAD: begin
        // IV layout: {bsid, 1, uiuc, 1, frame, 1}; held until the next burst.
        iv_d     = {bsid_q, 1'b1, uiuc_q, 1'b1, frame_q, 1'b1};
        reload_d = 1'b1;
      end
      S_DATA: begin
        if (xfer) begin
          in_valid_d = 1'b1;
          in_bits_d  = src_bit_i;
          in_cnt_d   = in_cnt_inc;
        end
      end
      S_PAD: begin
        in_valid_d = 1'b1;
        in_bits_d  = 1'b1;
        in_cnt_d   = in_cnt_inc;
      end
      S_DRAIN: begin
        done_d        = out_full;
        err_timeout_d = stall_exp;
      end
      default: ;
    endcase
  end

  // The stall counter only runs in DRAIN and restarts on every output strobe.
  always_comb begin
    stall_d = '0;
    if ((state_q == S_DRAIN) && !rnd_out_valid_i) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bsid_q        <= '0;
      uiuc_q        <= '0;
      frame_q       <= '0;
      data_len_q    <= '0;
      slot_len_q    <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      stall_q       <= '0;
      iv_q          <= '0;
      in_bits_q     <= 1'b0;
      in_valid_q    <= 1'b0;
      reload_q      <= 1'b0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      bsid_q        <= bsid_d;
      uiuc_q        <= uiuc_d;
      frame_q       <= frame_d;
      data_len_q    <= data_len_d;
      slot_len_q    <= slot_len_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      stall_q       <= stall_d;
      iv_q          <= iv_d;
      in_bits_q     <= in_bits_d;
      in_valid_q    <= in_valid_d;
      reload_q      <= reload_d;
      done_q        <= done_d;
      err_cfg_q     <= err_cfg_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign rnd_in_bits_o  = in_bits_q;
  assign rnd_in_valid_o = in_valid_q;
  assign rnd_iv_o       = iv_q;
  assign rnd_reload_o   = reload_q;
  assign done_o         = done_q;
  assign err_cfg_o      = err_cfg_q;
  assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_randomizer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_randomizer_ctrl
//
// Self-checking bench for randomizer_ctrl. A small randomizer model returns
// one output strobe per input bit after a chosen latency, and can be told to
// stop after N strobes. A negedge monitor records the randomizer input
// stream and the pulse outputs. Each burst is checked against the expected
// stream, which is the payload bits followed by 1s up to slot_len.
// ---------------------------------------------------------------------------
module tb_randomizer_ctrl;

  localparam int LEN_W     = 16;
  localparam int DRAIN_MAX = 64;
  localparam int BOUND     = 600;

  logic             clk          = 1'b0;
  logic             reset        = 1'b0;
  logic             start        = 1'b0;
  logic             start_ready;
  logic [3:0]       cfg_bsid     = '0;
  logic [3:0]       cfg_uiuc     = '0;
  logic [3:0]       cfg_frame    = '0;
  logic [LEN_W-1:0] cfg_data_len = '0;
  logic [LEN_W-1:0] cfg_slot_len = '0;
  logic             src_bit      = 1'b0;
  logic             src_valid    = 1'b0;
  logic             src_ready;
  logic             rnd_in_bits;
  logic             rnd_in_valid;
  logic [14:0]      rnd_iv;
  logic             rnd_reload;
  logic             rnd_out_valid;
  logic             busy;
  logic             done;
  logic             err_cfg;
  logic             err_timeout;

  randomizer_ctrl #(
    .LEN_W    (LEN_W),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .start_ready_o  (start_ready),
    .cfg_bsid_i     (cfg_bsid),
    .cfg_uiuc_i     (cfg_uiuc),
    .cfg_frame_i    (cfg_frame),
    .cfg_data_len_i (cfg_data_len),
    .cfg_slot_len_i (cfg_slot_len),
    .src_bit_i      (src_bit),
    .src_valid_i    (src_valid),
    .src_ready_o    (src_ready),
    .rnd_in_bits_o  (rnd_in_bits),
    .rnd_in_valid_o (rnd_in_valid),
    .rnd_iv_o       (rnd_iv),
    .rnd_reload_o   (rnd_reload),
    .rnd_out_valid_i(rnd_out_valid),
    .busy_o         (busy),
    .done_o         (done),
    .err_cfg_o      (err_cfg),
    .err_timeout_o  (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- randomizer model: fixed latency, optional cut-off -----
  int       lat       = 1;
  int       out_total = 0;
  int       out_limit = 32'h3fff_ffff;
  logic [2:0] lat_sr  = '0;
  logic     raw_out;

  always_comb begin
    case (lat)
      0:       raw_out = rnd_in_valid;
      1:       raw_out = lat_sr[0];
      2:       raw_out = lat_sr[1];
      default: raw_out = lat_sr[2];
    endcase
  end

  assign rnd_out_valid = raw_out && (out_total < out_limit);

  always @(posedge clk) begin
    lat_sr <= {lat_sr[1:0], rnd_in_valid};
    if (rnd_out_valid) out_total <= out_total + 1;
  end

  // ---------------- monitor ----------------------------------------------
  bit mon_q[$];
  int last_in_cyc  = 0;
  int last_out_cyc = 0;
  int reload_cnt   = 0;
  int reload_cyc   = 0;
  int done_cnt     = 0;
  int done_cyc     = 0;
  int tmo_cnt      = 0;
  int tmo_cyc      = 0;
  int ecfg_cnt     = 0;
  int ecfg_cyc     = 0;

  always @(negedge clk) begin
    if (rnd_in_valid === 1'b1) begin
      mon_q.push_back(rnd_in_bits);
      last_in_cyc = cyc;
    end
    if (rnd_out_valid === 1'b1) last_out_cyc = cyc;
    if (rnd_reload === 1'b1) begin reload_cnt++; reload_cyc = cyc; end
    if (done === 1'b1)       begin done_cnt++;   done_cyc   = cyc; end
    if (err_timeout === 1'b1) begin tmo_cnt++;   tmo_cyc    = cyc; end
    if (err_cfg === 1'b1)    begin ecfg_cnt++;   ecfg_cyc   = cyc; end
  end

  // Expected IV from its field layout, built with plain arithmetic.
  function automatic logic [14:0] iv_of(input logic [3:0] b, input logic [3:0] u,
                                        input logic [3:0] f);
    int v;
    v = int'(b) * 2048 + 1024 + int'(u) * 64 + 32 + int'(f) * 2 + 1;
    return v[14:0];
  endfunction

  // ---------------- one full burst ----------------------------------------
  // gap_pct < 0 selects a strict 1,0,1,0 src_valid pattern.
  // cut < 0 lets the model return every output; otherwise it stops after cut.
  task automatic run_burst(input string name, input int dl, input int sl,
                           input int gap_pct, input int l,
                           input logic [3:0] b, input logic [3:0] u, input logic [3:0] f,
                           input logic [63:0] data, input bit junk, input int cut);
    int base_q, base_rl, base_dn, base_tm, idx, t0, bad, got_n;
    bit valid_s, ready_s, cur_bit, finished, exp_bit;
    logic [14:0] exp_iv;

    lat       = l;
    out_limit = (cut < 0) ? 32'h3fff_ffff : out_total + cut;
    base_q    = mon_q.size();
    base_rl   = reload_cnt;
    base_dn   = done_cnt;
    base_tm   = tmo_cnt;
    exp_iv    = iv_of(b, u, f);

    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start_ready: got %b expected 1", name, start_ready);
    end

    start = 1'b1; cfg_bsid = b; cfg_uiuc = u; cfg_frame = f;
    cfg_data_len = LEN_W'(dl); cfg_slot_len = LEN_W'(sl);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0; finished = 1'b0;
    for (int c = 0; c < BOUND && !finished; c++) begin
      if (gap_pct < 0) valid_s = (idx < dl) && (c % 2 == 0);
      else             valid_s = (idx < dl) && ($urandom_range(99) >= gap_pct);
      cur_bit   = (idx < dl) ? data[idx] : 1'b0;
      src_valid = valid_s;
      src_bit   = cur_bit;
      ready_s   = src_ready;
      // Junk requests while streaming must be ignored.
      if (junk && ready_s) begin
        start = 1'b1; cfg_bsid = 4'($urandom); cfg_uiuc = 4'($urandom);
        cfg_frame = 4'($urandom); cfg_data_len = 1; cfg_slot_len = 2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (ready_s) begin
        checks++;
        if (rnd_in_valid !== valid_s || (valid_s && rnd_in_bits !== cur_bit)) begin
          errors++;
          $display("FAIL %s data_mirror: got valid=%b bit=%b expected valid=%b bit=%b",
                   name, rnd_in_valid, rnd_in_bits, valid_s, cur_bit);
        end
        if (valid_s) idx++;
      end
      finished = (done_cnt != base_dn) || (tmo_cnt != base_tm);
    end
    start = 1'b0;
    src_valid = 1'b0;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s burst_end: got no done/timeout within %0d cycles expected end", name, BOUND);
    end

    checks++;
    if (idx !== dl) begin
      errors++;
      $display("FAIL %s src_transfers: got %0d expected %0d", name, idx, dl);
    end

    got_n = mon_q.size() - base_q;
    checks++;
    if (got_n !== sl) begin
      errors++;
      $display("FAIL %s in_valid_count: got %0d expected %0d", name, got_n, sl);
    end

    bad = 0;
    for (int i = 0; i < sl && i < got_n; i++) begin
      exp_bit = (i < dl) ? data[i] : 1'b1;
      if (mon_q[base_q + i] !== exp_bit) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s in_stream: got %0d wrong bits expected 0", name, bad);
    end

    checks++;
    if (reload_cnt - base_rl !== 1 || reload_cyc !== t0 + 2) begin
      errors++;
      $display("FAIL %s reload: got %0d pulses at +%0d expected 1 pulse at +2",
               name, reload_cnt - base_rl, reload_cyc - t0);
    end

    checks++;
    if (rnd_iv !== exp_iv) begin
      errors++;
      $display("FAIL %s iv: got %h expected %h", name, rnd_iv, exp_iv);
    end

    if (cut < 0) begin
      checks++;
      if (done_cnt - base_dn !== 1 || tmo_cnt !== base_tm) begin
        errors++;
        $display("FAIL %s done_count: got done=%0d timeout=%0d expected done=1 timeout=0",
                 name, done_cnt - base_dn, tmo_cnt - base_tm);
      end
      checks++;
      if (done_cyc <= last_out_cyc || done_cyc > last_out_cyc + 2) begin
        errors++;
        $display("FAIL %s done_timing: got done %0d cycles after last out_valid expected 1..2",
                 name, done_cyc - last_out_cyc);
      end
    end else begin
      checks++;
      if (tmo_cnt - base_tm !== 1 || done_cnt !== base_dn) begin
        errors++;
        $display("FAIL %s timeout_count: got timeout=%0d done=%0d expected timeout=1 done=0",
                 name, tmo_cnt - base_tm, done_cnt - base_dn);
      end
      // Draining starts in the cycle the last input bit is presented.
      checks++;
      if (tmo_cyc - last_in_cyc !== DRAIN_MAX) begin
        errors++;
        $display("FAIL %s timeout_timing: got %0d stalled cycles expected %0d",
                 name, tmo_cyc - last_in_cyc, DRAIN_MAX);
      end
    end

    checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b start_ready=%b expected busy=0 start_ready=1",
               name, busy, start_ready);
    end
    $display("burst %s: dl=%0d sl=%0d lat=%0d gap=%0d cut=%0d checked", name, dl, sl, l, gap_pct, cut);
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    logic [23:0] got;
    #1 reset = 1'b1;
    #1;
    got = {start_ready, busy, src_ready, rnd_in_bits, rnd_in_valid, rnd_reload,
           done, err_cfg, err_timeout, rnd_iv};
    checks++;
    if (got !== 24'h80_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", got, 24'h80_0000);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_iv();
    run_burst("iv", 4, 6, 0, 1, 4'd1, 4'd7, 4'd3, 64'h9, 1'b0, -1);
    checks++;
    if (rnd_iv !== 15'h0DE7) begin
      errors++;
      $display("FAIL iv_const: got %h expected 0de7", rnd_iv);
    end
  endtask

  task automatic test_pad();
    run_burst("pad_a5", 8, 12, 0, 1, 4'd2, 4'd5, 4'd9, 64'hA5, 1'b0, -1);
  endtask

  task automatic test_gaps();
    run_burst("gaps", 6, 9, -1, 2, 4'd4, 4'd1, 4'd14, 64'h2D, 1'b0, -1);
  endtask

  task automatic test_cfg_error();
    int dls[2];
    int sls[2];
    int base_e, base_rl, t0;
    bit busy_seen;
    dls[0] = 6; sls[0] = 4;
    dls[1] = 0; sls[1] = 0;
    for (int k = 0; k < 2; k++) begin
      base_e = ecfg_cnt; base_rl = reload_cnt;
      start = 1'b1; cfg_data_len = LEN_W'(dls[k]); cfg_slot_len = LEN_W'(sls[k]);
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      busy_seen = 1'b0;
      repeat (4) begin
        if (busy !== 1'b0) busy_seen = 1'b1;
        @(posedge clk); #1;
      end
      checks++;
      if (ecfg_cnt - base_e !== 1 || ecfg_cyc !== t0 + 1) begin
        errors++;
        $display("FAIL cfg_err_pulse: got %0d pulses at +%0d expected 1 at +1",
                 ecfg_cnt - base_e, ecfg_cyc - t0);
      end
      checks++;
      if (busy_seen || reload_cnt !== base_rl) begin
        errors++;
        $display("FAIL cfg_err_idle: got busy_seen=%b reloads=%0d expected 0 0",
                 busy_seen, reload_cnt - base_rl);
      end
      $display("test_cfg_error: dl=%0d sl=%0d rejected", dls[k], sls[k]);
    end
    run_burst("pad_only", 0, 3, 0, 1, 4'd3, 4'd3, 4'd3, 64'h0, 1'b0, -1);
  endtask

  task automatic test_timeout();
    run_burst("timeout", 8, 12, 0, 1, 4'd6, 4'd2, 4'd1, 64'h5A, 1'b0, 5);
  endtask

  task automatic test_reset_mid();
    int x;
    bit rs;
    logic [23:0] got;
    lat = 1; out_limit = 32'h3fff_ffff;
    start = 1'b1; cfg_data_len = 10; cfg_slot_len = 12;
    @(posedge clk); #1;
    start = 1'b0;
    x = 0;
    for (int c = 0; c < 40 && x < 5; c++) begin
      src_valid = 1'b1; src_bit = 1'(c);
      rs = src_ready;
      @(posedge clk); #1;
      if (rs) x++;
    end
    checks++;
    if (x !== 5) begin
      errors++;
      $display("FAIL reset_mid_setup: got %0d transfers expected 5", x);
    end
    #2 reset = 1'b1;
    #1;
    got = {start_ready, busy, src_ready, rnd_in_bits, rnd_in_valid, rnd_reload,
           done, err_cfg, err_timeout, rnd_iv};
    checks++;
    if (got !== 24'h80_0000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected %h", got, 24'h80_0000);
    end
    src_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("test_reset_mid: reset during DATA checked");
    run_burst("after_reset", 5, 7, 20, 1, 4'd9, 4'd8, 4'd7, 64'h13, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_0", 10, 10, 0, 0, 4'd15, 4'd0, 4'd15, 64'h3C5, 1'b1, -1);
    run_burst("b2b_1", 7, 11, 30, 3, 4'd0, 4'd15, 4'd0, 64'h6B, 1'b1, -1);
  endtask

  task automatic test_random();
    int dl, sl;
    for (int k = 0; k < 6; k++) begin
      dl = $urandom_range(20);
      sl = dl + $urandom_range(8);
      if (sl == 0) sl = 1;
      run_burst("random", dl, sl, $urandom_range(60), $urandom_range(3),
                4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom},
                1'(k), -1);
    end
  endtask

  initial begin
    test_reset();
    test_iv();
    test_pad();
    test_gaps();
    test_cfg_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
